// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch channel: request/address out, ack/data back.
// Latency: none, wires only; the memory may ack in the same cycle as the request.
// Backpressure: the master holds req and addr until the slave acks.
// Signals: imem_req/imem_addr (master to slave), imem_ack/imem_rdata (slave to master).
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// MIPS multicycle fetch stage: holds the PC and the IR, fetches one word per instruction, decodes fields.
// Latency: IR loads on the ack edge and instr_valid rises the next cycle; the PC commits on the pc_load edge.
// Backpressure: waits without limit in FETCH for imem_ack; pc_load is honoured only while HOLD presents an instruction.
// Ports: i_clock, i_reset (async, active-low), imem (fetch channel master),
//        i_pc_load/i_branch_mux_s/i_j_mux_s (from control FSM), o_pc/o_pc_plus4,
//        o_instr_valid, decoded o_opcode/o_rs/o_rt/o_rd/o_funct/o_imm_sext, o_fault.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              i_clock,
    input  logic              i_reset,
    fetch_unit_if.master      imem,
    input  logic              i_pc_load,
    input  logic              i_branch_mux_s,
    input  logic              i_j_mux_s,
    output logic [31:0]       o_pc,
    output logic [31:0]       o_pc_plus4,
    output logic              o_instr_valid,
    output logic [5:0]        o_opcode,
    output logic [4:0]        o_rs,
    output logic [4:0]        o_rt,
    output logic [4:0]        o_rd,
    output logic [5:0]        o_funct,
    output logic [31:0]       o_imm_sext,
    output logic              o_fault
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_ir;
    logic [31:0] w_ir_nxt;
    logic        w_req;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_imm_sext;
    logic [31:0] w_branch_tgt;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_next_pc;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_imm_sext   = {{16{r_ir[15]}}, r_ir[15:0]};
    // Word offset: the top two bits of the sign-extended immediate fall off, modulo 2^32.
    assign w_branch_tgt = w_pc_plus4 + {w_imm_sext[29:0], 2'b00};
    assign w_jump_tgt   = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};
    // A jump takes priority over a branch when both selects are raised.
    assign w_next_pc    = i_j_mux_s      ? w_jump_tgt   :
                          i_branch_mux_s ? w_branch_tgt : w_pc_plus4;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_req       = 1'b0;
        case (r_state)
            S_FETCH: begin
                // A misaligned PC (only a bad RESET_PC can produce one) must never reach memory.
                if (r_pc[1:0] != 2'b00) begin
                    w_state_nxt = S_FAULT;
                end else begin
                    w_req = 1'b1;
                    if (imem.imem_ack) begin
                        w_ir_nxt    = imem.imem_rdata;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (i_pc_load) begin
                    w_pc_nxt    = w_next_pc;
                    w_state_nxt = (w_next_pc[1:0] != 2'b00) ? S_FAULT : S_FETCH;
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_FAULT;
            end
        endcase
    end

    // Gating with reset drops the request the moment reset asserts, without waiting for a clock.
    assign imem.imem_req  = w_req & i_reset;
    assign imem.imem_addr = r_pc;

    assign o_pc          = r_pc;
    assign o_pc_plus4    = w_pc_plus4;
    assign o_instr_valid = (r_state == S_HOLD);
    assign o_fault       = (r_state == S_FAULT);
    assign o_opcode      = r_ir[31:26];
    assign o_rs          = r_ir[25:21];
    assign o_rt          = r_ir[20:16];
    assign o_rd          = r_ir[15:11];
    assign o_funct       = r_ir[5:0];
    assign o_imm_sext    = w_imm_sext;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: instance A uses an aligned reset PC, instance B a misaligned one.
// Latency: inputs are driven at the falling edge and outputs are sampled 1 time unit later.
// Backpressure: the bench plays the memory and acks after a chosen number of wait cycles.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic pc_load = 1'b0;
    logic br_s = 1'b0;
    logic j_s = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_unit_if ifa();
    fetch_unit_if ifb();

    logic [31:0] pc_a, pc4_a, imm_a, pc_b, pc4_b, imm_b;
    logic        valid_a, fault_a, valid_b, fault_b;
    logic [5:0]  op_a, fn_a, op_b, fn_b;
    logic [4:0]  rs_a, rt_a, rd_a, rs_b, rt_b, rd_b;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
        .i_clock(clk), .i_reset(rst_a), .imem(ifa.master),
        .i_pc_load(pc_load), .i_branch_mux_s(br_s), .i_j_mux_s(j_s),
        .o_pc(pc_a), .o_pc_plus4(pc4_a), .o_instr_valid(valid_a),
        .o_opcode(op_a), .o_rs(rs_a), .o_rt(rt_a), .o_rd(rd_a),
        .o_funct(fn_a), .o_imm_sext(imm_a), .o_fault(fault_a));

    fetch_unit #(.RESET_PC(32'h0000_0002)) dut_b (
        .i_clock(clk), .i_reset(rst_b), .imem(ifb.master),
        .i_pc_load(pc_load), .i_branch_mux_s(br_s), .i_j_mux_s(j_s),
        .o_pc(pc_b), .o_pc_plus4(pc4_b), .o_instr_valid(valid_b),
        .o_opcode(op_b), .o_rs(rs_b), .o_rt(rt_b), .o_rd(rd_b),
        .o_funct(fn_b), .o_imm_sext(imm_b), .o_fault(fault_b));

    // Fetches one word from instance A: the call starts at a sample point in FETCH and ends in HOLD.
    task automatic do_fetch(input string nm, input logic [31:0] addr, input logic [31:0] word,
                            input int delay, input logic [5:0] exp_op, input logic [31:0] exp_imm);
        for (int i = 0; i < delay; i++) begin
            n_cmp++;
            if (ifa.imem_req !== 1'b1) begin
                n_err++; $display("FAIL %s wait req: got %b want 1", nm, ifa.imem_req);
            end
            n_cmp++;
            if (ifa.imem_addr !== addr) begin
                n_err++; $display("FAIL %s wait addr: got %h want %h", nm, ifa.imem_addr, addr);
            end
            // A pc_load pulse while the fetch is still waiting must be ignored.
            pc_load = (i == 1);
            j_s     = (i == 1);
            @(negedge clk);
            #1;
        end
        pc_load = 1'b0;
        j_s     = 1'b0;
        n_cmp++;
        if (ifa.imem_req !== 1'b1 || ifa.imem_addr !== addr) begin
            n_err++; $display("FAIL %s req/addr: got %b/%h want 1/%h", nm, ifa.imem_req, ifa.imem_addr, addr);
        end
        ifa.imem_ack   = 1'b1;
        ifa.imem_rdata = word;
        @(negedge clk);
        ifa.imem_ack   = 1'b0;
        ifa.imem_rdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (valid_a !== 1'b1 || ifa.imem_req !== 1'b0) begin
            n_err++; $display("FAIL %s hold valid/req: got %b/%b want 1/0", nm, valid_a, ifa.imem_req);
        end
        n_cmp++;
        if (op_a !== exp_op || imm_a !== exp_imm) begin
            n_err++; $display("FAIL %s decode op/imm: got %h/%h want %h/%h", nm, op_a, imm_a, exp_op, exp_imm);
        end
        n_cmp++;
        if (pc_a !== addr) begin
            n_err++; $display("FAIL %s pc: got %h want %h", nm, pc_a, addr);
        end
    endtask

    // Pulses pc_load while HOLD is presenting an instruction, then checks that the new fetch has started.
    task automatic commit(input string nm, input logic j, input logic b, input logic [31:0] exp_pc,
                          input logic [31:0] exp_pc4);
        pc_load = 1'b1; j_s = j; br_s = b;
        @(negedge clk);
        pc_load = 1'b0; j_s = 1'b0; br_s = 1'b0;
        #1;
        n_cmp++;
        if (pc_a !== exp_pc || pc4_a !== exp_pc4) begin
            n_err++; $display("FAIL %s pc/pc4: got %h/%h want %h/%h", nm, pc_a, pc4_a, exp_pc, exp_pc4);
        end
        n_cmp++;
        if (valid_a !== 1'b0 || ifa.imem_req !== 1'b1 || ifa.imem_addr !== exp_pc) begin
            n_err++; $display("FAIL %s refetch valid/req/addr: got %b/%b/%h want 0/1/%h",
                              nm, valid_a, ifa.imem_req, ifa.imem_addr, exp_pc);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (ifa.imem_req !== 1'b0 || valid_a !== 1'b0 || fault_a !== 1'b0) begin
            n_err++; $display("FAIL reset req/valid/fault: got %b/%b/%b want 0/0/0", ifa.imem_req, valid_a, fault_a);
        end
        n_cmp++;
        if (pc_a !== 32'd0 || pc4_a !== 32'd4) begin
            n_err++; $display("FAIL reset pc/pc4: got %h/%h want 0/4", pc_a, pc4_a);
        end
        n_cmp++;
        if (op_a !== 6'd0 || rs_a !== 5'd0 || rd_a !== 5'd0 || fn_a !== 6'd0 || imm_a !== 32'd0) begin
            n_err++; $display("FAIL reset fields: got op %h rs %h rd %h fn %h imm %h want 0", op_a, rs_a, rd_a, fn_a, imm_a);
        end
        rst_a = 1'b1;
        #1;
        n_cmp++;
        if (ifa.imem_req !== 1'b1 || ifa.imem_addr !== 32'd0) begin
            n_err++; $display("FAIL first req/addr: got %b/%h want 1/0", ifa.imem_req, ifa.imem_addr);
        end
    endtask

    task automatic test_sequential();
        do_fetch("add", 32'h0, 32'h0109_5020, 0, 6'h00, 32'h0000_5020);
        n_cmp++;
        if (rs_a !== 5'd8 || rt_a !== 5'd9 || rd_a !== 5'd10 || fn_a !== 6'h20) begin
            n_err++; $display("FAIL add fields: got rs %0d rt %0d rd %0d fn %h want 8 9 10 20", rs_a, rt_a, rd_a, fn_a);
        end
        commit("seq0", 1'b0, 1'b0, 32'h4, 32'h8);
        do_fetch("nop4", 32'h4, 32'h0, 0, 6'h00, 32'h0);
        commit("seq4", 1'b0, 1'b0, 32'h8, 32'hC);
    endtask

    task automatic test_branch();
        do_fetch("beqneg", 32'h8, 32'h1000_FFFE, 0, 6'h04, 32'hFFFF_FFFE);
        commit("brneg", 1'b0, 1'b1, 32'h4, 32'h8);
        do_fetch("nop4b", 32'h4, 32'h0, 0, 6'h00, 32'h0);
        commit("seq4b", 1'b0, 1'b0, 32'h8, 32'hC);
        do_fetch("beqpos", 32'h8, 32'h1000_0003, 0, 6'h04, 32'h0000_0003);
        commit("brpos", 1'b0, 1'b1, 32'h18, 32'h1C);
    endtask

    task automatic test_jump();
        do_fetch("jfar", 32'h18, 32'h0BFF_FFFF, 0, 6'h02, 32'hFFFF_FFFF);
        commit("jfar", 1'b1, 1'b0, 32'h0FFF_FFFC, 32'h1000_0000);
        do_fetch("nopedge", 32'h0FFF_FFFC, 32'h0, 0, 6'h00, 32'h0);
        commit("seqedge", 1'b0, 1'b0, 32'h1000_0000, 32'h1000_0004);
        do_fetch("j10", 32'h1000_0000, 32'h0800_0010, 0, 6'h02, 32'h0000_0010);
        commit("jboth", 1'b1, 1'b1, 32'h1000_0040, 32'h1000_0044);
    endtask

    task automatic test_slow_mem();
        do_fetch("slow", 32'h1000_0040, 32'h2108_0001, 5, 6'h08, 32'h0000_0001);
        // An ack that arrives while no request is outstanding must leave the IR untouched.
        ifa.imem_ack = 1'b1; ifa.imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        ifa.imem_ack = 1'b0;
        #1;
        n_cmp++;
        if (op_a !== 6'h08 || imm_a !== 32'h1 || valid_a !== 1'b1) begin
            n_err++; $display("FAIL stray ack op/imm/valid: got %h/%h/%b want 08/00000001/1", op_a, imm_a, valid_a);
        end
        commit("slowseq", 1'b0, 1'b0, 32'h1000_0044, 32'h1000_0048);
    endtask

    task automatic test_reset_mid();
        rst_a = 1'b0;
        #1;
        n_cmp++;
        if (ifa.imem_req !== 1'b0 || pc_a !== 32'd0 || valid_a !== 1'b0) begin
            n_err++; $display("FAIL midreset req/pc/valid: got %b/%h/%b want 0/0/0", ifa.imem_req, pc_a, valid_a);
        end
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        n_cmp++;
        if (ifa.imem_req !== 1'b1 || ifa.imem_addr !== 32'd0) begin
            n_err++; $display("FAIL postreset req/addr: got %b/%h want 1/0", ifa.imem_req, ifa.imem_addr);
        end
    endtask

    task automatic test_wrap();
        do_fetch("beqwrap", 32'h0, 32'h1000_FFFE, 0, 6'h04, 32'hFFFF_FFFE);
        commit("brwrap", 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000);
        do_fetch("noptop", 32'hFFFF_FFFC, 32'h0, 0, 6'h00, 32'h0);
        commit("seqwrap", 1'b0, 1'b0, 32'h0, 32'h4);
    endtask

    task automatic test_fault();
        ifb.imem_ack = 1'b0; ifb.imem_rdata = 32'h0;
        rst_b = 1'b1;
        #1;
        n_cmp++;
        if (ifb.imem_req !== 1'b0 || fault_b !== 1'b0) begin
            n_err++; $display("FAIL misaligned first cycle req/fault: got %b/%b want 0/0", ifb.imem_req, fault_b);
        end
        ifb.imem_ack = 1'b1; ifb.imem_rdata = 32'h0800_0010;
        for (int i = 0; i < 3; i++) begin
            pc_load = 1'b1;
            br_s    = (i == 1);
            @(negedge clk);
            #1;
            n_cmp++;
            if (fault_b !== 1'b1 || ifb.imem_req !== 1'b0 || valid_b !== 1'b0 || pc_b !== 32'h2) begin
                n_err++; $display("FAIL fault sticky %0d fault/req/valid/pc: got %b/%b/%b/%h want 1/0/0/00000002",
                                  i, fault_b, ifb.imem_req, valid_b, pc_b);
            end
        end
        pc_load = 1'b0; br_s = 1'b0; ifb.imem_ack = 1'b0;
        rst_b = 1'b0;
        #1;
        n_cmp++;
        if (fault_b !== 1'b0 || op_b !== 6'd0) begin
            n_err++; $display("FAIL fault cleared by reset fault/op: got %b/%h want 0/00", fault_b, op_b);
        end
    endtask

    initial begin
        ifa.imem_ack = 1'b0; ifa.imem_rdata = 32'h0;
        ifb.imem_ack = 1'b0; ifb.imem_rdata = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_slow_mem();
        test_reset_mid();
        test_wrap();
        test_fault();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
